// File: rtl/ex_ctrl_pkg.sv
// Shared types and helpers for the execute-stage pipeline controller.
package ex_ctrl_pkg;

    localparam int REG_W  = 4;
    localparam int FLAG_W = 3;
    localparam int CNT_W  = 16;

    // Flag bit positions inside the {zr,neg,ov} vector.
    localparam int FLAG_Z = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        RUN    = 2'b00,
        DRAIN  = 2'b01,
        HALTED = 2'b10
    } ctrl_state_e;

    typedef enum logic [2:0] {
        BC_NE = 3'b000,
        BC_EQ = 3'b001,
        BC_GT = 3'b010,
        BC_LT = 3'b011,
        BC_GE = 3'b100,
        BC_LE = 3'b101,
        BC_OV = 3'b110,
        BC_AL = 3'b111
    } bcond_e;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_e;

    // Evaluates a branch condition code against the architectural flags.
    function automatic logic branch_cond(input logic [2:0] code,
                                         input logic [FLAG_W-1:0] fl);
        logic z;
        logic n;
        logic v;
        logic res;
        z = fl[FLAG_Z];
        n = fl[FLAG_N];
        v = fl[FLAG_V];
        case (bcond_e'(code))
            BC_NE:   res = ~z;
            BC_EQ:   res = z;
            BC_GT:   res = ~z & ~n;
            BC_LT:   res = n;
            BC_GE:   res = z | ~n;
            BC_LE:   res = z | n;
            BC_OV:   res = v;
            BC_AL:   res = 1'b1;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/ex_fwd_unit.sv
// Combinational ALU operand forwarding selects for the instruction in EX.
module ex_fwd_unit
    import ex_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] ex_rs_i,
    input  logic [REG_W-1:0] ex_rt_i,
    input  logic [REG_W-1:0] mem_rd_i,
    input  logic             mem_regwrite_i,
    input  logic [REG_W-1:0] wb_rd_i,
    input  logic             wb_regwrite_i,
    output fwd_sel_e         fwd_a_o,
    output fwd_sel_e         fwd_b_o
);

    logic mem_can_fwd;
    logic wb_can_fwd;

    // A stage only forwards if it really writes back and its target is not r0.
    always_comb begin
        mem_can_fwd = mem_regwrite_i && (mem_rd_i != '0);
        wb_can_fwd  = wb_regwrite_i  && (wb_rd_i  != '0);
    end

    // Operand A select; the younger EX/MEM result wins over MEM/WB.
    always_comb begin
        fwd_a_o = FWD_RF;
        if (mem_can_fwd && (mem_rd_i == ex_rs_i)) begin
            fwd_a_o = FWD_MEM;
        end else if (wb_can_fwd && (wb_rd_i == ex_rs_i)) begin
            fwd_a_o = FWD_WB;
        end
    end

    // Operand B select, same priority as operand A.
    always_comb begin
        fwd_b_o = FWD_RF;
        if (mem_can_fwd && (mem_rd_i == ex_rt_i)) begin
            fwd_b_o = FWD_MEM;
        end else if (wb_can_fwd && (wb_rd_i == ex_rt_i)) begin
            fwd_b_o = FWD_WB;
        end
    end

endmodule

// File: rtl/ex_stage_ctrl.sv
// Execute-stage pipeline controller: flags, branch resolution, hazards,
// memory freeze and halt/drain sequencing.
module ex_stage_ctrl
    import ex_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic              id_uses_rt,
    input  logic [REG_W-1:0]  ex_rs,
    input  logic [REG_W-1:0]  ex_rt,
    input  logic [REG_W-1:0]  ex_rd,
    input  logic              ex_memread,
    input  logic [2:0]        ex_bcond,
    input  logic              ex_branch,
    input  logic              ex_halt,
    input  logic [FLAG_W-1:0] ex_flags,
    input  logic [FLAG_W-1:0] ex_flag_we,
    input  logic [REG_W-1:0]  mem_rd,
    input  logic [REG_W-1:0]  wb_rd,
    input  logic              mem_regwrite,
    input  logic              wb_regwrite,
    input  logic              mem_req,
    input  logic              mem_ready,
    output logic [FLAG_W-1:0] flags,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              br_taken,
    output logic              pc_we,
    output logic              ifid_we,
    output logic              idex_we,
    output logic              exmem_we,
    output logic              memwb_we,
    output logic              ifid_flush,
    output logic              idex_flush,
    output logic              halted,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam logic [1:0] S_RUN    = RUN;
    localparam logic [1:0] S_DRAIN  = DRAIN;
    localparam logic [1:0] S_HALTED = HALTED;

    // The drain ends after the counter has seen this value.
    localparam logic [1:0] DRAIN_LAST = 2'd1;

    logic [1:0]        state_q, state_d;
    logic [1:0]        drain_cnt_q, drain_cnt_d;
    logic [FLAG_W-1:0] flags_q, flags_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic     freeze;
    logic     take;
    logic     load_use;
    logic     inc_stall;
    logic     inc_flush;
    fwd_sel_e fwd_a_raw;
    fwd_sel_e fwd_b_raw;

    ex_fwd_unit u_fwd (
        .ex_rs_i        (ex_rs),
        .ex_rt_i        (ex_rt),
        .mem_rd_i       (mem_rd),
        .mem_regwrite_i (mem_regwrite),
        .wb_rd_i        (wb_rd),
        .wb_regwrite_i  (wb_regwrite),
        .fwd_a_o        (fwd_a_raw),
        .fwd_b_o        (fwd_b_raw)
    );

    // Hazard detection: memory freeze, branch resolution and load-use.
    always_comb begin
        freeze   = mem_req & ~mem_ready;
        take     = ex_branch & branch_cond(ex_bcond, flags_q);
        load_use = ex_memread && (ex_rd != '0) &&
                   ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
    end

    // Per-cycle stage control, in priority order reset > freeze > halt > branch > load-use.
    always_comb begin
        pc_we      = 1'b0;
        ifid_we    = 1'b0;
        idex_we    = 1'b0;
        exmem_we   = 1'b0;
        memwb_we   = 1'b0;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        br_taken   = 1'b0;
        inc_stall  = 1'b0;
        inc_flush  = 1'b0;
        if (!rst) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (!freeze) begin
            case (state_q)
                S_HALTED: begin
                end
                S_DRAIN: begin
                    idex_we    = 1'b1;
                    exmem_we   = 1'b1;
                    memwb_we   = 1'b1;
                    idex_flush = 1'b1;
                end
                default: begin
                    if (ex_halt) begin
                        idex_we    = 1'b1;
                        exmem_we   = 1'b1;
                        memwb_we   = 1'b1;
                        idex_flush = 1'b1;
                    end else if (take) begin
                        pc_we      = 1'b1;
                        ifid_we    = 1'b1;
                        idex_we    = 1'b1;
                        exmem_we   = 1'b1;
                        memwb_we   = 1'b1;
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                        br_taken   = 1'b1;
                        inc_flush  = 1'b1;
                    end else if (load_use) begin
                        idex_we    = 1'b1;
                        exmem_we   = 1'b1;
                        memwb_we   = 1'b1;
                        idex_flush = 1'b1;
                        inc_stall  = 1'b1;
                    end else begin
                        pc_we      = 1'b1;
                        ifid_we    = 1'b1;
                        idex_we    = 1'b1;
                        exmem_we   = 1'b1;
                        memwb_we   = 1'b1;
                    end
                end
            endcase
        end
    end

    // Halt/drain sequencing; frozen cycles do not advance the drain.
    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        if (!freeze) begin
            case (state_q)
                S_RUN: begin
                    if (ex_halt) begin
                        state_d     = S_DRAIN;
                        drain_cnt_d = 2'd0;
                    end
                end
                S_DRAIN: begin
                    drain_cnt_d = drain_cnt_q + 2'd1;
                    if (drain_cnt_q == DRAIN_LAST) begin
                        state_d = S_HALTED;
                    end
                end
                S_HALTED: begin
                end
                default: begin
                    state_d = S_RUN;
                end
            endcase
        end
    end

    // Flag register and saturating performance counters next values.
    always_comb begin
        for (int i = 0; i < FLAG_W; i++) begin
            flags_d[i] = (ex_flag_we[i] && !freeze) ? ex_flags[i] : flags_q[i];
        end
        stall_cnt_d = (inc_stall && (stall_cnt_q != '1)) ? stall_cnt_q + 16'd1 : stall_cnt_q;
        flush_cnt_d = (inc_flush && (flush_cnt_q != '1)) ? flush_cnt_q + 16'd1 : flush_cnt_q;
    end

    // State, flags and counters with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_RUN;
            drain_cnt_q <= 2'd0;
            flags_q     <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            flags_q     <= flags_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Output drive; forwarding and halted are forced inactive during reset.
    always_comb begin
        flags     = flags_q;
        stall_cnt = stall_cnt_q;
        flush_cnt = flush_cnt_q;
        fwd_a     = rst ? fwd_a_raw : FWD_RF;
        fwd_b     = rst ? fwd_b_raw : FWD_RF;
        halted    = rst && (state_q == S_HALTED);
    end

endmodule

// File: tb/tb_ex_stage_ctrl.sv
// Self-checking bench for ex_stage_ctrl: behavioural model plus directed pins.
module tb_ex_stage_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
    logic        id_uses_rt, ex_memread, ex_branch, ex_halt;
    logic [2:0]  ex_bcond, ex_flags, ex_flag_we;
    logic        mem_regwrite, wb_regwrite, mem_req, mem_ready;
    logic [2:0]  flags;
    logic [1:0]  fwd_a, fwd_b;
    logic        br_taken, pc_we, ifid_we, idex_we, exmem_we, memwb_we;
    logic        ifid_flush, idex_flush, halted;
    logic [15:0] stall_cnt, flush_cnt;

    int tests = 0;
    int fails = 0;

    // Model state: drainLeft < 0 running, > 0 unfrozen drain cycles left, 0 halted.
    int drainLeft = -1;
    bit mZ = 0, mN = 0, mV = 0;
    int mStalls = 0;
    int mFlushes = 0;

    ex_stage_ctrl dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_memread(ex_memread), .ex_bcond(ex_bcond), .ex_branch(ex_branch),
        .ex_halt(ex_halt), .ex_flags(ex_flags), .ex_flag_we(ex_flag_we),
        .mem_rd(mem_rd), .wb_rd(wb_rd),
        .mem_regwrite(mem_regwrite), .wb_regwrite(wb_regwrite),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .flags(flags), .fwd_a(fwd_a), .fwd_b(fwd_b), .br_taken(br_taken),
        .pc_we(pc_we), .ifid_we(ifid_we), .idex_we(idex_we),
        .exmem_we(exmem_we), .memwb_we(memwb_we),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .halted(halted),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    function automatic bit condTrue(input int code);
        case (code)
            0: return !mZ;
            1: return mZ;
            2: return !mZ && !mN;
            3: return mN;
            4: return mZ || !mN;
            5: return mZ || mN;
            6: return mV;
            default: return 1;
        endcase
    endfunction

    function automatic int fwdOf(input logic [3:0] src);
        if (mem_regwrite && mem_rd != 0 && mem_rd == src) return 1;
        if (wb_regwrite && wb_rd != 0 && wb_rd == src) return 2;
        return 0;
    endfunction

    function automatic bit loadUse();
        return ex_memread && ex_rd != 0 &&
               (ex_rd == id_rs || (id_uses_rt && ex_rd == id_rt));
    endfunction

    // Compare every output against the model away from the active edge.
    always @(negedge clk) begin
        bit fz;
        int eWe, eIfF, eIdF, eBt, eHl, eFa, eFb;
        fz = mem_req && !mem_ready;
        eWe = 0; eIfF = 0; eIdF = 0; eBt = 0; eHl = 0; eFa = 0; eFb = 0;
        if (!rst) begin
            eIfF = 1; eIdF = 1;
        end else begin
            eFa = fwdOf(ex_rs);
            eFb = fwdOf(ex_rt);
            eHl = (drainLeft == 0);
            if (!fz) begin
                if (drainLeft == 0) begin
                    eWe = 0;
                end else if (drainLeft > 0 || ex_halt) begin
                    eWe = 5'b00111; eIdF = 1;
                end else if (ex_branch && condTrue(int'(ex_bcond))) begin
                    eWe = 5'b11111; eIfF = 1; eIdF = 1; eBt = 1;
                end else if (loadUse()) begin
                    eWe = 5'b00111; eIdF = 1;
                end else begin
                    eWe = 5'b11111;
                end
            end
        end
        checkOutput("enables", {pc_we, ifid_we, idex_we, exmem_we, memwb_we}, eWe);
        checkOutput("ifid_flush", ifid_flush, eIfF);
        checkOutput("idex_flush", idex_flush, eIdF);
        checkOutput("br_taken", br_taken, eBt);
        checkOutput("halted", halted, eHl);
        checkOutput("fwd_a", fwd_a, eFa);
        checkOutput("fwd_b", fwd_b, eFb);
        checkOutput("flags", flags, {mZ, mN, mV});
        checkOutput("stall_cnt", stall_cnt, mStalls);
        checkOutput("flush_cnt", flush_cnt, mFlushes);
    end

    // Advance the model on each active edge from the inputs of that cycle.
    always @(posedge clk) begin
        bit fz;
        fz = mem_req && !mem_ready;
        if (!rst) begin
            drainLeft = -1; mZ = 0; mN = 0; mV = 0; mStalls = 0; mFlushes = 0;
        end else if (!fz) begin
            if (ex_flag_we[2]) mZ = ex_flags[2];
            if (ex_flag_we[1]) mN = ex_flags[1];
            if (ex_flag_we[0]) mV = ex_flags[0];
            if (drainLeft > 0) begin
                drainLeft--;
            end else if (drainLeft < 0) begin
                if (ex_halt) drainLeft = 2;
                else if (ex_branch && condTrue(int'(ex_bcond))) begin
                    if (mFlushes < 65535) mFlushes++;
                end else if (loadUse()) begin
                    if (mStalls < 65535) mStalls++;
                end
            end
        end
    end

    task automatic idle();
        id_rs = 4'd1; id_rt = 4'd2; id_uses_rt = 1'b0;
        ex_rs = 4'd8; ex_rt = 4'd9; ex_rd = 4'd0;
        ex_memread = 1'b0; ex_bcond = 3'd0; ex_branch = 1'b0; ex_halt = 1'b0;
        ex_flags = 3'd0; ex_flag_we = 3'd0;
        mem_rd = 4'd0; wb_rd = 4'd0; mem_regwrite = 1'b0; wb_regwrite = 1'b0;
        mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    // Let the current input vector be clocked in, then return just after the edge.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        idle();
        rst = 1'b0;
        applyStimulus();
        applyStimulus();
        settle();
        checkOutput("rst pc_we", pc_we, 0);
        checkOutput("rst idex_flush", idex_flush, 1);
        rst = 1'b1;
        settle();
        checkOutput("post-rst pc_we", pc_we, 1);
        checkOutput("post-rst stall_cnt", stall_cnt, 0);
        checkOutput("post-rst flags", flags, 0);
        applyStimulus();

        // Forwarding priority and r0 exclusion
        mem_rd = 4'd3; mem_regwrite = 1'b1; wb_rd = 4'd3; wb_regwrite = 1'b1;
        ex_rs = 4'd3; ex_rt = 4'd3;
        settle();
        checkOutput("fwd mem prio", fwd_a, 2'b01);
        mem_rd = 4'd0;
        settle();
        checkOutput("fwd r0 skip", fwd_a, 2'b10);
        checkOutput("fwd_b wb", fwd_b, 2'b10);
        applyStimulus();
        idle();

        // Load-use on rs, then with r0 destination
        ex_memread = 1'b1; ex_rd = 4'd5; id_rs = 4'd5;
        settle();
        checkOutput("lu pc_we", pc_we, 0);
        checkOutput("lu ifid_we", ifid_we, 0);
        checkOutput("lu idex_flush", idex_flush, 1);
        applyStimulus();
        ex_rd = 4'd0; id_rs = 4'd0;
        settle();
        checkOutput("lu stall_cnt", stall_cnt, 1);
        checkOutput("lu r0 pc_we", pc_we, 1);
        applyStimulus();
        idle();

        // Load-use through rt only when the ID instruction reads rt
        ex_memread = 1'b1; ex_rd = 4'd7; id_rt = 4'd7; id_uses_rt = 1'b1;
        settle();
        checkOutput("lu rt stall", pc_we, 0);
        applyStimulus();
        id_uses_rt = 1'b0;
        applyStimulus();
        idle();

        // Flag load then branch on it
        ex_flags = 3'b100; ex_flag_we = 3'b100;
        applyStimulus();
        idle();
        ex_branch = 1'b1; ex_bcond = 3'b001;
        settle();
        checkOutput("flags Z", flags, 3'b100);
        checkOutput("beq taken", br_taken, 1);
        checkOutput("beq ifid_flush", ifid_flush, 1);
        applyStimulus();
        ex_bcond = 3'b000;
        settle();
        checkOutput("beq flush_cnt", flush_cnt, 1);
        checkOutput("bne not taken", br_taken, 0);
        applyStimulus();

        // Taken branch masks a concurrent load-use
        ex_bcond = 3'b001; ex_memread = 1'b1; ex_rd = 4'd5; id_rs = 4'd5;
        settle();
        checkOutput("br+lu pc_we", pc_we, 1);
        applyStimulus();
        idle();
        settle();
        checkOutput("br+lu stall_cnt", stall_cnt, 2);
        checkOutput("br+lu flush_cnt", flush_cnt, 2);

        // Memory freeze for four cycles with all flags enabled
        mem_req = 1'b1; mem_ready = 1'b0; ex_flags = 3'b011; ex_flag_we = 3'b111;
        ex_branch = 1'b1; ex_bcond = 3'b111;
        for (int i = 0; i < 4; i++) begin
            settle();
            checkOutput("frz pc_we", pc_we, 0);
            checkOutput("frz br_taken", br_taken, 0);
            applyStimulus();
        end
        mem_ready = 1'b1; ex_flag_we = 3'b000; ex_branch = 1'b0;
        settle();
        checkOutput("frz flags held", flags, 3'b100);
        checkOutput("release memwb_we", memwb_we, 1);
        applyStimulus();
        idle();

        // Branch condition table across flag patterns
        ex_flags = 3'b001; ex_flag_we = 3'b111;
        applyStimulus();
        ex_flag_we = 3'b000;
        ex_branch = 1'b1; ex_bcond = 3'b110;
        settle();
        checkOutput("bov taken", br_taken, 1);
        ex_bcond = 3'b011;
        settle();
        checkOutput("blt not taken", br_taken, 0);
        applyStimulus();
        for (int f = 0; f < 8; f++) begin
            ex_branch = 1'b0; ex_flags = 3'(f); ex_flag_we = 3'b111;
            applyStimulus();
            ex_flag_we = 3'b000;
            for (int c = 0; c < 8; c++) begin
                ex_branch = 1'b1; ex_bcond = 3'(c);
                applyStimulus();
            end
        end
        idle();
        applyStimulus();

        // Halt with one frozen cycle inside the drain
        ex_halt = 1'b1;
        settle();
        checkOutput("hlt pc_we", pc_we, 0);
        applyStimulus();
        ex_halt = 1'b0; mem_req = 1'b1; mem_ready = 1'b0;
        applyStimulus();
        mem_req = 1'b0;
        applyStimulus();
        settle();
        checkOutput("drain halted low", halted, 0);
        applyStimulus();
        settle();
        checkOutput("halted after 4", halted, 1);
        checkOutput("halted memwb_we", memwb_we, 0);
        mem_req = 1'b1;
        applyStimulus();
        settle();
        checkOutput("halted under freeze", halted, 1);
        mem_req = 1'b0;
        applyStimulus();

        // Reset out of HALTED
        rst = 1'b0;
        settle();
        checkOutput("rst halted", halted, 0);
        applyStimulus();
        rst = 1'b1;
        settle();
        checkOutput("rerun halted", halted, 0);
        checkOutput("rerun stall_cnt", stall_cnt, 0);
        checkOutput("rerun flush_cnt", flush_cnt, 0);
        checkOutput("rerun pc_we", pc_we, 1);
        applyStimulus();
        applyStimulus();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
